// File: rtl/swc_packet_mem_write_pump_pkg.sv
// swc_packet_mem_write_pump_pkg: default geometry of the packet memory write pump
package swc_packet_mem_write_pump_pkg;
  localparam int C_PAGE_ADDR_BITS = 10;
  localparam int C_PAGE_SIZE = 128;
  localparam int C_INPUT_WIDTH = 32;
  localparam int C_MULTIPLY = 16;
  localparam int C_LINE_BITS = $clog2(C_PAGE_SIZE / C_MULTIPLY);
endpackage

// File: rtl/swc_packet_mem_write_pump.sv
// swc_packet_mem_write_pump: packs input words into memory lines and writes them on the pump's access slot
module swc_packet_mem_write_pump
  import swc_packet_mem_write_pump_pkg::*;
#(
  parameter int g_page_addr_bits = C_PAGE_ADDR_BITS,
  parameter int g_page_size = C_PAGE_SIZE,
  parameter int g_input_width = C_INPUT_WIDTH,
  parameter int g_multiply = C_MULTIPLY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [g_page_addr_bits-1:0] pgaddr_i,
  input  logic pgreq_i,
  input  logic drdy_i,
  input  logic [g_input_width-1:0] d_i,
  output logic full_o,
  input  logic flush_i,
  input  logic sync_i,
  output logic [g_input_width*g_multiply-1:0] q_o,
  output logic we_o,
  output logic [g_page_addr_bits+$clog2(g_page_size/g_multiply)-1:0] addr_o,
  output logic pgend_o
);
  localparam int L = g_page_size / g_multiply;
  localparam int LB = $clog2(L);
  localparam int CB = $clog2(g_multiply + 1);
  localparam int SB = (g_multiply > 1) ? $clog2(g_multiply) : 1;
  logic [CB-1:0] r_cnt;
  logic [g_multiply-1:0][g_input_width-1:0] r_reg;
  logic r_flush;
  logic [g_page_addr_bits-1:0] r_page;
  logic [LB-1:0] r_off;
  logic w_acc, w_pend, w_commit, w_flush_nxt;
  logic [CB-1:0] w_cnt_nxt;
  // full_o mirrors the pending state, so a full register can never accept a word
  always_comb begin
    w_pend = (r_cnt == CB'(g_multiply)) | r_flush;
    w_acc = drdy_i & ~full_o;
    w_commit = w_pend & sync_i;
    w_cnt_nxt = w_commit ? '0 : r_cnt + CB'(w_acc);
    w_flush_nxt = ~w_commit & (r_flush | (flush_i & ((r_cnt != '0) | w_acc)));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_reg <= '0;
      r_flush <= 1'b0;
      r_page <= '0;
      r_off <= '0;
      full_o <= 1'b0;
      we_o <= 1'b0;
      pgend_o <= 1'b0;
      q_o <= '0;
      addr_o <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_flush <= w_flush_nxt;
      full_o <= (w_cnt_nxt == CB'(g_multiply)) | w_flush_nxt;
      we_o <= w_commit;
      pgend_o <= w_commit & (r_off == LB'(L - 1));
      if (w_commit) begin
        q_o <= r_reg;
        addr_o <= {r_page, r_off};
        r_reg <= '0;
      end else if (w_acc) begin
        r_reg[r_cnt[SB-1:0]] <= d_i;
      end
      if (pgreq_i) begin
        r_page <= pgaddr_i;
        r_off <= '0;
      end else if (w_commit) begin
        r_off <= r_off + LB'(1);
      end
    end
  end
endmodule

// File: tb/tb_swc_packet_mem_write_pump.sv
// tb_swc_packet_mem_write_pump: directed checks of packing, flush, paging, drop and reset behaviour
module tb_swc_packet_mem_write_pump;
  logic clk_i, rst_i, pgreq_i, drdy_i, flush_i, sync_i;
  logic [9:0] pgaddr_i;
  logic [31:0] d_i;
  logic full_o, we_o, pgend_o;
  logic [511:0] q_o;
  logic [12:0] addr_o;
  int n_chk = 0, n_pass = 0, n_rd = 0;
  logic [511:0] wq_q[$];
  logic [12:0] wq_a[$];
  logic wq_e[$];
  logic [511:0] e;

  swc_packet_mem_write_pump dut (
    .clk_i(clk_i), .rst_i(rst_i), .pgaddr_i(pgaddr_i), .pgreq_i(pgreq_i),
    .drdy_i(drdy_i), .d_i(d_i), .full_o(full_o), .flush_i(flush_i),
    .sync_i(sync_i), .q_o(q_o), .we_o(we_o), .addr_o(addr_o), .pgend_o(pgend_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    sync_i = 1'b0;
    forever begin
      repeat (10) @(negedge clk_i);
      sync_i = 1'b1;
      @(negedge clk_i);
      sync_i = 1'b0;
    end
  end

  always @(negedge clk_i)
    if (we_o) begin
      wq_q.push_back(q_o);
      wq_a.push_back(addr_o);
      wq_e.push_back(pgend_o);
    end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put(input logic [31:0] d);
    int t = 0;
    while (full_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 200) chk("put_timeout", 1, 0);
    drdy_i = 1'b1;
    d_i = d;
    @(negedge clk_i);
    drdy_i = 1'b0;
  endtask

  task automatic flush();
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [511:0] eq, input logic [12:0] ea, input logic ee);
    int t = 0;
    while (wq_q.size() <= n_rd && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (wq_q.size() <= n_rd) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_q"}, wq_q[n_rd], eq);
    chk({tag, "_addr"}, 512'(wq_a[n_rd]), 512'(ea));
    chk({tag, "_pgend"}, 512'(wq_e[n_rd]), 512'(ee));
    n_rd++;
  endtask

  initial begin
    rst_i = 1'b1; pgreq_i = 1'b0; drdy_i = 1'b0; flush_i = 1'b0;
    pgaddr_i = '0; d_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_full", 512'(full_o), 0);
    chk("rst_we", 512'(we_o), 0);
    chk("rst_pgend", 512'(pgend_o), 0);
    chk("rst_q", q_o, 0);
    chk("rst_addr", 512'(addr_o), 0);
    // one full line of 0..15
    for (int i = 0; i < 15; i++) put(32'(i));
    chk("fill_not_full", 512'(full_o), 0);
    put(32'd15);
    chk("fill_full", 512'(full_o), 1);
    e = '0;
    for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'(k);
    pop("line0", e, 13'h000, 1'b0);
    chk("after_commit_full", 512'(full_o), 0);
    // three full lines then a flush with nothing buffered
    for (int i = 0; i < 48; i++) put(32'(100 + i));
    for (int l = 0; l < 3; l++) begin
      e = '0;
      for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'(100 + 16*l + k);
      pop($sformatf("line48_%0d", l), e, 13'(1 + l), 1'b0);
    end
    flush();
    repeat (30) @(negedge clk_i);
    chk("empty_flush_nowrite", 512'(wq_q.size()), 512'(n_rd));
    chk("empty_flush_full", 512'(full_o), 0);
    // partial line: last word arrives together with flush
    for (int i = 0; i < 4; i++) put(32'hA0 + 32'(i));
    drdy_i = 1'b1; d_i = 32'hA4; flush_i = 1'b1;
    @(negedge clk_i);
    drdy_i = 1'b0; flush_i = 1'b0;
    chk("flush_full", 512'(full_o), 1);
    e = '0;
    for (int k = 0; k < 5; k++) e[32*k +: 32] = 32'hA0 + 32'(k);
    pop("partial", e, 13'h004, 1'b0);
    // page load and wrap across eight lines
    pgaddr_i = 10'h2A; pgreq_i = 1'b1;
    @(negedge clk_i);
    pgreq_i = 1'b0;
    for (int l = 0; l < 9; l++) begin
      put(32'h500 + 32'(l));
      flush();
      e = '0;
      e[31:0] = 32'h500 + 32'(l);
      pop($sformatf("page_%0d", l), e, 13'h150 + 13'(l % 8), l == 7);
    end
    // word offered while full is dropped
    for (int i = 0; i < 16; i++) put(32'h200 + 32'(i));
    chk("drop_full", 512'(full_o), 1);
    drdy_i = 1'b1; d_i = 32'hDEAD;
    @(negedge clk_i);
    drdy_i = 1'b0;
    e = '0;
    for (int k = 0; k < 16; k++) e[32*k +: 32] = 32'h200 + 32'(k);
    pop("drop_line", e, 13'h151, 1'b0);
    put(32'h300);
    flush();
    e = '0;
    e[31:0] = 32'h300;
    pop("after_drop", e, 13'h152, 1'b0);
    // reset in the middle of a fill
    for (int i = 0; i < 3; i++) put(32'h700 + 32'(i));
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_q", q_o, 0);
    chk("midrst_addr", 512'(addr_o), 0);
    chk("midrst_full", 512'(full_o), 0);
    flush();
    repeat (30) @(negedge clk_i);
    chk("midrst_nowrite", 512'(wq_q.size()), 512'(n_rd));
    chk("midrst_we", 512'(we_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
